// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the multi-channel flexible counter.
// The mode encoding is split into a direction bit and a one-shot bit.
package flex_counter_pkg;

    typedef enum logic [1:0] {
        UP_WRAP      = 2'b00,
        UP_ONESHOT   = 2'b01,
        DOWN_WRAP    = 2'b10,
        DOWN_ONESHOT = 2'b11
    } cnt_mode_t;

    localparam int MODE_DOWN_BIT    = 1;
    localparam int MODE_ONESHOT_BIT = 0;

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: clear > load > step > hold, with wrap/one-shot,
// up/down modes, a registered terminal-count flag and a sticky done flag.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            step,
    input  logic            clear,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  cnt_mode_t       mode,
    input  logic [SIZE-1:0] rollover_val,
    output logic [SIZE-1:0] count_out,
    output logic            tc_flag,
    output logic            done
);

    logic [1:0]      mode_bits;
    logic            is_down;
    logic            is_oneshot;
    logic            r_zero;
    logic [SIZE-1:0] term_val;
    logic [SIZE-1:0] step_val;
    logic [SIZE-1:0] next_count;

    assign mode_bits  = mode;
    assign is_down    = mode_bits[MODE_DOWN_BIT];
    assign is_oneshot = mode_bits[MODE_ONESHOT_BIT];
    assign r_zero     = (rollover_val == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        term_val = rollover_val;
        step_val = count_out;
        if (r_zero) begin
            term_val = '0;
            step_val = '0;
        end else if (is_down) begin
            term_val = SIZE'(1);
            if (is_oneshot && count_out == SIZE'(1))
                step_val = count_out;
            else if (count_out <= SIZE'(1) || count_out > rollover_val)
                step_val = rollover_val;
            else
                step_val = count_out - SIZE'(1);
        end else begin
            if (is_oneshot && count_out == rollover_val)
                step_val = count_out;
            else if (count_out >= rollover_val)
                step_val = SIZE'(1);
            else
                step_val = count_out + SIZE'(1);
        end
    end

    always_comb begin
        next_count = count_out;
        if (clear)
            next_count = '0;
        else if (load)
            next_count = load_val;
        else if (step)
            next_count = step_val;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out <= '0;
            tc_flag   <= 1'b0;
            done      <= 1'b0;
        end else begin
            count_out <= next_count;
            tc_flag   <= (next_count == term_val) & ~clear;
            if (clear || load)
                done <= 1'b0;
            else if (is_oneshot && !r_zero && next_count == term_val)
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/flex_counter_mc.sv
// Multi-channel flexible counter: a shared prescaler produces a registered
// tick that qualifies each channel's count enable.
module flex_counter_mc
    import flex_counter_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int NUM_CH  = 2,
    parameter int PRESC_W = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         global_en,
    input  logic [PRESC_W-1:0]           prescale_val,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH-1:0][SIZE-1:0]  load_val,
    input  logic [NUM_CH-1:0]            count_enable,
    input  logic [NUM_CH-1:0][1:0]       mode,
    input  logic [NUM_CH-1:0][SIZE-1:0]  rollover_val,
    output logic [NUM_CH-1:0][SIZE-1:0]  count_out,
    output logic [NUM_CH-1:0]            tc_flag,
    output logic [NUM_CH-1:0]            done,
    output logic                         tick
);

    logic [PRESC_W-1:0] presc;

    // Wrapping on >= lets a lowered prescale_val take effect on the next cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (global_en) begin
            if (presc >= prescale_val) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + PRESC_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .SIZE(SIZE)
        ) u_ch (
            .clk          (clk),
            .n_rst        (n_rst),
            .step         (count_enable[i] & tick),
            .clear        (clear[i]),
            .load         (load[i]),
            .load_val     (load_val[i]),
            .mode         (cnt_mode_t'(mode[i])),
            .rollover_val (rollover_val[i]),
            .count_out    (count_out[i]),
            .tc_flag      (tc_flag[i]),
            .done         (done[i])
        );
    end

endmodule

// File: tb/tb_flex_counter_mc.sv
// Directed bench for flex_counter_mc with hand-computed expected values.
module tb_flex_counter_mc;
    import flex_counter_pkg::*;

    localparam int SIZE    = 4;
    localparam int NUM_CH  = 2;
    localparam int PRESC_W = 4;

    logic                        clk = 1'b0;
    logic                        n_rst;
    logic                        global_en;
    logic [PRESC_W-1:0]          prescale_val;
    logic [NUM_CH-1:0]           clear;
    logic [NUM_CH-1:0]           load;
    logic [NUM_CH-1:0][SIZE-1:0] load_val;
    logic [NUM_CH-1:0]           count_enable;
    logic [NUM_CH-1:0][1:0]      mode;
    logic [NUM_CH-1:0][SIZE-1:0] rollover_val;
    logic [NUM_CH-1:0][SIZE-1:0] count_out;
    logic [NUM_CH-1:0]           tc_flag;
    logic [NUM_CH-1:0]           done;
    logic                        tick;

    int n_vec = 0;
    int n_bad = 0;

    flex_counter_mc #(.SIZE(SIZE), .NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .global_en    (global_en),
        .prescale_val (prescale_val),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .mode         (mode),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .tc_flag      (tc_flag),
        .done         (done),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input int cnt, input int tc, input int dn);
        check({tag, ".count"}, 32'(count_out[ch]), cnt);
        check({tag, ".tc"},    32'(tc_flag[ch]),   tc);
        check({tag, ".done"},  32'(done[ch]),      dn);
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int up_cnt[6]   = '{1, 2, 3, 4, 5, 1};
        int up_tc[6]    = '{0, 0, 0, 0, 1, 0};
        int dn_cnt[6]   = '{4, 3, 2, 1, 1, 1};
        int dn_flag[6]  = '{0, 0, 0, 1, 1, 1};
        int tick_pat[6] = '{0, 0, 1, 0, 0, 1};

        n_rst        = 1'b0;
        global_en    = 1'b1;
        prescale_val = 4'd2;
        clear        = '0;
        load         = '0;
        load_val     = '0;
        count_enable = '0;
        mode[0]      = UP_WRAP;
        mode[1]      = DOWN_ONESHOT;
        rollover_val[0] = 4'd5;
        rollover_val[1] = 4'd4;

        // Reset held for two edges, then prescaler period of 3.
        step_clk();
        step_clk();
        check("rst.tick", 32'(tick), 0);
        chk_ch("rst.ch0", 0, 0, 0, 0);
        chk_ch("rst.ch1", 1, 0, 0, 0);
        n_rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_clk();
            check($sformatf("presc.tick%0d", k), 32'(tick), tick_pat[k]);
        end

        // Tick every cycle from now on.
        prescale_val = 4'd0;
        step_clk();
        check("presc0.tick", 32'(tick), 1);

        // UP_WRAP on ch0, R=5.
        count_enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_clk();
            chk_ch($sformatf("upwrap%0d", k), 0, up_cnt[k], up_tc[k], 0);
        end
        count_enable[0] = 1'b0;

        // DOWN_ONESHOT on ch1, R=4, from 0.
        count_enable[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_clk();
            chk_ch($sformatf("dnos%0d", k), 1, dn_cnt[k], dn_flag[k], dn_flag[k]);
        end
        check("dnos.ch0_hold", 32'(count_out[0]), 1);
        clear[1] = 1'b1;
        step_clk();
        chk_ch("dnos.clear", 1, 0, 0, 0);
        clear[1]        = 1'b0;
        count_enable[1] = 1'b0;

        // Priority on ch0: clear beats load beats step.
        clear[0]        = 1'b1;
        load[0]         = 1'b1;
        load_val[0]     = 4'd7;
        count_enable[0] = 1'b1;
        step_clk();
        chk_ch("prio.clear", 0, 0, 0, 0);
        clear[0]        = 1'b0;
        count_enable[0] = 1'b0;
        step_clk();
        chk_ch("prio.load", 0, 7, 0, 0);
        load[0]         = 1'b0;
        count_enable[0] = 1'b1;
        step_clk();
        chk_ch("prio.step", 0, 1, 0, 0);

        // R=0: count forced to 0 with tc_flag set.
        rollover_val[0] = 4'd0;
        step_clk();
        chk_ch("r0", 0, 0, 1, 0);
        count_enable[0] = 1'b0;

        // Mid-run R change: 9 with R lowered to 5 wraps to 1.
        rollover_val[0] = 4'd12;
        load[0]         = 1'b1;
        load_val[0]     = 4'd9;
        step_clk();
        chk_ch("rchg.load", 0, 9, 0, 0);
        load[0]         = 1'b0;
        rollover_val[0] = 4'd5;
        count_enable[0] = 1'b1;
        step_clk();
        chk_ch("rchg.step", 0, 1, 0, 0);
        count_enable[0] = 1'b0;

        // Synchronous reset mid-count.
        load[0]     = 1'b1;
        load_val[0] = 4'd3;
        step_clk();
        check("srst.pre", 32'(count_out[0]), 3);
        load[0] = 1'b0;
        n_rst   = 1'b0;
        #2;
        check("srst.noasync", 32'(count_out[0]), 3);
        step_clk();
        chk_ch("srst.ch0", 0, 0, 0, 0);
        chk_ch("srst.ch1", 1, 0, 0, 0);
        check("srst.tick", 32'(tick), 0);
        n_rst = 1'b1;
        step_clk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/flex_counter_mc.md
Name: flex_counter_mc

Overview:
- Parametrised multi-channel successor to the single-channel flexible counter.
- NUM_CH independent counters share one clock, one synchronous reset and one prescaler.
- Each channel has its own rollover value, mode (up/down, wrap/one-shot), parallel load, clear and enable.
- Serves as the timer/tick source for pipeline stall timers, baud dividers and watchdog-style timeouts.

Parameters:
- SIZE, 4, width of each channel counter and of its rollover/load values.
- NUM_CH, 2, number of independent channels (1..16).
- PRESC_W, 4, width of the shared prescaler counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- n_rst  input  1  reset, synchronous, active-low: sampled only on rising clk.
- global_en  input  1  enables the prescaler; when 0, no channel counts.
- prescale_val  input  PRESC_W  tick period minus 1; 0 = tick every cycle.
- clear  input  NUM_CH  per-channel synchronous clear.
- load  input  NUM_CH  per-channel parallel load strobe.
- load_val  input  NUM_CH x SIZE  per-channel load value, packed [NUM_CH-1:0][SIZE-1:0].
- count_enable  input  NUM_CH  per-channel count enable, qualified by tick.
- mode  input  NUM_CH x 2  per-channel mode, packed [NUM_CH-1:0][1:0].
- rollover_val  input  NUM_CH x SIZE  per-channel rollover value R.
- count_out  output  NUM_CH x SIZE  registered count.
- tc_flag  output  NUM_CH  registered terminal-count flag.
- done  output  NUM_CH  registered one-shot completion flag.
- tick  output  1  registered prescaler tick, for observation.

Behaviour:
- Reset (n_rst=0 at a rising edge): prescaler=0, tick=0, every count_out=0, tc_flag=0, done=0. Reset mid-count aborts immediately; no asynchronous path.
- Prescaler: increments while global_en=1 and holds while 0.
  - When it equals prescale_val: wraps to 0 and tick register=1 for the next cycle; otherwise tick=0.
  - prescale_val=0 with global_en=1 gives tick=1 every cycle from the second cycle after enable.
  - A change of prescale_val below the current prescaler value forces a wrap on the next cycle.
- Channel step condition: step = count_enable[i] & tick.
- Per-channel priority: clear > load > step > hold.
  - clear: count=0, tc_flag=0, done=0.
  - load: count=load_val, done=0, and tc_flag recomputed from the loaded value.
- Terminal value T: T=R in up modes; T=1 in down modes; T=0 when R=0.
- Modes (package enum):
  - UP_WRAP (00): step when count>=R gives 1, else count+1. Sequence from 0 is 1..R,1..R. Identical to legacy counter behaviour.
  - UP_ONESHOT (01): as UP_WRAP, but holds once count==R. done=1 from that cycle.
  - DOWN_WRAP (10): step when count<=1 or count>R gives R, else count-1. Sequence from 0 is R..1,R..1.
  - DOWN_ONESHOT (11): as DOWN_WRAP, but holds once count==1. done=1 from that cycle.
- R=0, any mode: step yields count=0 and tc_flag=1. Counting is suppressed and done stays 0.
- Flag timing: tc_flag is registered as (next_count==T) & ~clear. It is high exactly while count_out==T, in the same cycle, and is not a one-cycle pulse unless the count moves on.
- done is sticky until clear, load or reset. In a one-shot mode it is set when next_count==T.
- Mode or R change mid-count: no count reset; takes effect on the next step.
  - Example: count 9 with R lowered to 5 in UP_WRAP gives 1 on the next step.
- Arithmetic is unsigned SIZE-bit; no intermediate overflow is possible given the compares.
- Channels are fully independent: simultaneous clear/load/step on different channels all apply in the same cycle.

Decomposition:
- Package flex_counter_pkg:
  - cnt_mode_t enum {UP_WRAP, UP_ONESHOT, DOWN_WRAP, DOWN_ONESHOT} (2-bit).
  - Constant MODE_DOWN_BIT=1 (mode bit 1 selects down).
  - Constant MODE_ONESHOT_BIT=0.
- Sub-module flex_counter_ch: one channel, parameter SIZE, inputs step/clear/load/load_val/mode/rollover_val, outputs count_out/tc_flag/done.
- Top: prescaler plus a generate loop of NUM_CH flex_counter_ch instances.

Test Plan:
- Reset and prescaler (SIZE=4, prescale_val=2, global_en=1): hold n_rst=0 for 2 cycles, then release -> all outputs 0; tick high 1 of every 3 cycles.
- UP_WRAP ch0 (R=5, prescale_val=0, enable held): count_out 1,2,3,4,5,1.
  - tc_flag=1 only in the cycle(s) count_out=5; done stays 0.
- DOWN_ONESHOT ch1 (R=4, from cleared 0): count_out 4,3,2,1,1,1.
  - tc_flag and done go 1 with count_out=1 and stay 1.
  - Pulsing clear -> count 0, tc_flag 0, done 0 next cycle.
- Priority (ch0): clear=1, load=1 (load_val=7), enable=1 in the same cycle -> count 0.
  - Next cycle with load only -> 7.
  - Then UP_WRAP with R=5 and a step -> 1.
- R=0 and mid-run changes: R=0 with enable -> count 0, tc_flag=1.
  - Count at 9 (R=12, UP_WRAP), R set to 5 -> next step gives 1.
  - Assert n_rst=0 mid-count -> all 0 at the next edge only, with no asynchronous clear.
